fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that drives the read port of the unified 16-bit instruction/data block RAM. It maintains the fetch PC, issues one read per cycle into the RAM's registered read path, absorbs the one-cycle read latency with a 2-entry instruction buffer, and presents {instr, instr_pc} to decode through a valid/ready handshake. Decode or execute can redirect fetch (branch/jump) at any time. All buffered and in-flight words are flushed on redirect.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address after reset.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- mem_addr  out  16  RAM port address; equals fetch_pc register.
- mem_en  out  1  RAM port write enable; constant 0 (read-only port).
- mem_rdata  in  16  RAM port read data; holds ram[mem_addr of previous cycle].
- redirect  in  1  load new fetch PC and flush; highest priority after reset.
- redirect_pc  in  16  target PC, sampled when redirect=1.
- instr  out  16  instruction word at buffer head.
- instr_pc  out  16  address of instr.
- instr_valid  out  1  buffer head holds a valid word.
- instr_ready  in  1  consumer accepts head this cycle (pop = instr_valid & instr_ready).

## Operation
- State: fetch_pc[15:0], inflight (1 bit), inflight_pc[15:0], 2-entry FIFO of {pc, word}, count[1:0] (0..2).
- Issue: in cycle t, issue = !reset & !redirect & (count + inflight - pop < 2). On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^16, 16'hFFFF wraps to 16'h0000). No issue: inflight<=0, fetch_pc holds.
- Capture: if inflight=1 and redirect=0, push {inflight_pc, mem_rdata} into FIFO. Credit rule guarantees push never occurs when full (after pop).
- Push and pop in same cycle: count unchanged; the pushed word goes behind the remaining entry. If count=0, no bypass; the word appears on outputs the next cycle.
- Redirect (cycle t, reset=0): count<=0, inflight<=0, in-flight response discarded, fetch_pc<=redirect_pc. Pop in the same cycle is still acknowledged to consumer but irrelevant (flushed). No issue in cycle t.
- Reset: fetch_pc<=RESET_PC, count<=0, inflight<=0, FIFO contents cleared to 0. Reset overrides redirect. Reset mid-stream discards everything.
- mem_addr is read by the RAM every cycle; responses with inflight=0 are ignored.
- Outputs are registered FIFO head: instr/instr_pc reflect entry 0; both 0 when count=0 after reset or flush.

## Timing
- Reset values: mem_addr=RESET_PC, mem_en=0, instr=0, instr_pc=0, instr_valid=0.
- Latency issue→valid: issue in cycle t, capture in t+1, instr_valid=1 in t+2.
- Reset released at edge E0: issue RESET_PC in cycle 1, instr_valid=1 in cycle 3.
- Redirect sampled at edge ending cycle t: mem_addr=redirect_pc in t+1 (issue), instr_valid=1 with instr_pc=redirect_pc in t+3. instr_valid=0 in t+1 and t+2.
- Throughput: with instr_ready held 1, one instruction per cycle, sequential PCs, no bubbles after first.
- Backpressure: while instr_valid=1 & instr_ready=0, instr/instr_pc/instr_valid held stable. Max 2 buffered + 0 in flight.

## Test plan
- RAM preload ram[i]=16'h0100+i; reset 2 cycles then instr_ready=1 -> instr_valid first high cycle 3 with instr=0x0100, instr_pc=0x0000; then 0x0101/0x0001, 0x0102/0x0002 each subsequent cycle, no gaps.
- Stream running, instr_ready=0 for 5 cycles then 1 -> outputs frozen during stall, count never exceeds 2, resumed sequence has no duplicated or skipped PC.
- FIFO full, redirect=1 with redirect_pc=0x0040 -> instr_valid=0 for 2 cycles, then instr_pc=0x0040, instr=0x0140; no stale pre-redirect word ever presented.
- redirect_pc=0xFFFE, instr_ready=1 -> instr_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- redirect and reset asserted in same cycle mid-stream -> reset wins: next valid instr_pc=RESET_PC at third cycle after release, mem_en=0 throughout.
- redirect in same cycle as a pop with count=1 -> the popped word is consumed once, queued/in-flight words dropped, next valid is the redirect target.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the RAM read port, absorbs its one-cycle read
// latency in a 2-entry buffer, and hands {instr, instr_pc} to decode via valid/ready.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [15:0] inflight_pc_q, inflight_pc_d;
  logic [15:0] e0_pc_q, e0_pc_d, e0_word_q, e0_word_d;
  logic [15:0] e1_pc_q, e1_pc_d, e1_word_q, e1_word_d;
  logic [1:0]  count_q, count_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;

  assign mem_addr    = fetch_pc_q;
  assign mem_en      = 1'b0;
  assign instr       = e0_word_q;
  assign instr_pc    = e0_pc_q;
  assign instr_valid = (count_q != 2'd0);

  always_comb begin
    pop   = instr_valid & instr_ready;
    // Credit: buffered + in-flight after this cycle's pop must leave room for one more.
    occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = !reset && !redirect && (occ < 3'd2);
    push  = inflight_q && !redirect;

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    e0_pc_d       = e0_pc_q;
    e0_word_d     = e0_word_q;
    e1_pc_d       = e1_pc_q;
    e1_word_d     = e1_word_q;
    count_d       = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      count_d    = 2'd0;
      e0_pc_d    = 16'h0000;
      e0_word_d  = 16'h0000;
      e1_pc_d    = 16'h0000;
      e1_word_d  = 16'h0000;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 16'd1;
      end
      // Slots beyond count are kept zero so the head reads 0 once drained.
      if (pop) begin
        e0_pc_d   = e1_pc_q;
        e0_word_d = e1_word_q;
        e1_pc_d   = 16'h0000;
        e1_word_d = 16'h0000;
        count_d   = count_q - 2'd1;
      end
      if (push) begin
        if (count_d == 2'd0) begin
          e0_pc_d   = inflight_pc_q;
          e0_word_d = mem_rdata;
        end else begin
          e1_pc_d   = inflight_pc_q;
          e1_word_d = mem_rdata;
        end
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
      e0_pc_q       <= 16'h0000;
      e0_word_q     <= 16'h0000;
      e1_pc_q       <= 16'h0000;
      e1_word_q     <= 16'h0000;
      count_q       <= 2'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      e0_pc_q       <= e0_pc_d;
      e0_word_q     <= e0_word_d;
      e1_pc_q       <= e1_pc_d;
      e1_word_q     <= e1_word_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; models a registered-read RAM with ram[i] = 16'h0100 + i.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_rdata = 16'h0000;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= 16'h0100 + mem_addr;

  task automatic test_reset();
    @(negedge clk); reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, instr_pc, instr, mem_addr, mem_en} !== {1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%0b pc=%h instr=%h addr=%h en=%0b, want 0/0000/0000/0000/0",
               instr_valid, instr_pc, instr, mem_addr, mem_en);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL startup_bubble: instr_valid got %0b want 0 (cycle 2)", instr_valid);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 16'(k), 16'(16'h0100 + k)}) begin
        n_bad++;
        $display("FAIL startup_stream[%0d]: got v=%0b pc=%h instr=%h, want 1/%h/%h",
                 k, instr_valid, instr_pc, instr, 16'(k), 16'(16'h0100 + k));
      end
    end
  endtask

  // Steady streaming: head P, fetch_pc = P+2.
  task automatic test_stall();
    logic [15:0] p;
    p = instr_pc;
    instr_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, instr_pc, instr, mem_addr} !== {1'b1, p, 16'(16'h0100 + p), 16'(p + 16'd2)}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got v=%0b pc=%h instr=%h addr=%h, want 1/%h/%h/%h",
                 i, instr_valid, instr_pc, instr, mem_addr, p, 16'(16'h0100 + p), 16'(p + 16'd2));
      end
      if (i == 5) instr_ready = 1'b1;
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 16'(p + k), 16'(16'h0100 + p + k)}) begin
        n_bad++;
        $display("FAIL stall_resume[%0d]: got v=%0b pc=%h instr=%h, want 1/%h/%h",
                 k, instr_valid, instr_pc, instr, 16'(p + k), 16'(16'h0100 + p + k));
      end
    end
  endtask

  task automatic test_redirect_full();
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++;
    if ({instr_valid, mem_addr, mem_en} !== {1'b0, 16'h0040, 1'b0}) begin
      n_bad++;
      $display("FAIL redir_full_t1: got v=%0b addr=%h en=%0b, want 0/0040/0", instr_valid, mem_addr, mem_en);
    end
    @(negedge clk);
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_full_t2: instr_valid got %0b want 0", instr_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0040, 16'h0140}) begin
      n_bad++;
      $display("FAIL redir_full_t3: got v=%0b pc=%h instr=%h, want 1/0040/0140", instr_valid, instr_pc, instr);
    end
    instr_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 16'(16'h0040 + k), 16'(16'h0140 + k)}) begin
        n_bad++;
        $display("FAIL redir_full_seq[%0d]: got v=%0b pc=%h instr=%h, want 1/%h/%h",
                 k, instr_valid, instr_pc, instr, 16'(16'h0040 + k), 16'(16'h0140 + k));
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_bubble: instr_valid got %0b want 0", instr_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc[k], 16'(16'h0100 + exp_pc[k])}) begin
        n_bad++;
        $display("FAIL wrap_seq[%0d]: got v=%0b pc=%h instr=%h, want 1/%h/%h",
                 k, instr_valid, instr_pc, instr, exp_pc[k], 16'(16'h0100 + exp_pc[k]));
      end
    end
  endtask

  task automatic test_reset_vs_redirect();
    instr_ready = 1'b1;
    reset = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
    @(negedge clk);
    reset = 1'b0; redirect = 1'b0;
    n_cmp++;
    if ({instr_valid, mem_addr, mem_en} !== {1'b0, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_wins_t1: got v=%0b addr=%h en=%0b, want 0/0000/0", instr_valid, mem_addr, mem_en);
    end
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, mem_en} !== {1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_wins_t2: got v=%0b en=%0b, want 0/0", instr_valid, mem_en);
    end
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, instr_pc, instr, mem_en} !== {1'b1, 16'h0000, 16'h0100, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_wins_t3: got v=%0b pc=%h instr=%h en=%0b, want 1/0000/0100/0",
               instr_valid, instr_pc, instr, mem_en);
    end
  endtask

  // Steady streaming leaves count=1 with a word in flight; redirect lands on a pop.
  task automatic test_redirect_pop();
    logic [15:0] p;
    @(negedge clk);
    @(negedge clk);
    p = instr_pc;
    n_cmp++;
    if ({instr_valid, instr} !== {1'b1, 16'(16'h0100 + p)}) begin
      n_bad++;
      $display("FAIL redir_pop_pre: got v=%0b instr=%h, want 1/%h", instr_valid, instr, 16'(16'h0100 + p));
    end
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0080;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_pop_t1: instr_valid got %0b (pc=%h) want 0", instr_valid, instr_pc);
    end
    @(negedge clk);
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_pop_t2: instr_valid got %0b (pc=%h) want 0", instr_valid, instr_pc);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 16'(16'h0080 + k), 16'(16'h0180 + k)}) begin
        n_bad++;
        $display("FAIL redir_pop_seq[%0d]: got v=%0b pc=%h instr=%h, want 1/%h/%h",
                 k, instr_valid, instr_pc, instr, 16'(16'h0080 + k), 16'(16'h0180 + k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_full();
    test_wrap();
    test_reset_vs_redirect();
    test_redirect_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
